// File: rtl/fetch_buffer.sv
// fetch_buffer: RV32I fetch stage that owns the PC and issues in-order word reads.
// It presents {pc, insn} pairs from a 2-entry buffer over valid/ready and flushes on redirect.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets sticky misalign_o and halts fetch.
module fetch_buffer #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic              misalign_o
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;

  logic [AWIDTH-1:0] pc_r;
  logic [AWIDTH-1:0] pc_next_s;
  logic [AWIDTH-1:0] redirect_target_s;

  logic [AWIDTH-1:0] buf_pc_r   [2];
  logic [DWIDTH-1:0] buf_insn_r [2];
  logic [AWIDTH-1:0] pcq_r      [2];

  logic              head_r;
  logic              tail_r;
  logic              pcq_wr_r;
  logic              pcq_rd_r;

  logic [1:0]        count_r;
  logic [1:0]        count_next_s;
  logic [1:0]        out_r;
  logic [1:0]        out_next_s;
  logic [1:0]        drop_r;
  logic [1:0]        drop_next_s;
  logic [2:0]        inflight_s;

  logic              valid_r;
  logic              valid_next_s;
  logic              misalign_hit_s;
  logic              req_s;
  logic              rsp_s;
  logic              push_s;
  logic              pop_s;

  // Redirect target and misalignment detection.
  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_target_s = redirect_pc_i;
    misalign_hit_s    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
    redirect_target_s = redirect_pc_i & ~AWIDTH'(2'b11);
    misalign_hit_s    = 1'b0;
`endif
  end

  // Request, response, handshake and next-state bookkeeping.
  always_comb begin
    inflight_s   = {1'b0, count_r} + {1'b0, out_r};
    req_s        = 1'b0;
    rsp_s        = imem_rsp_valid_i && (out_r != 2'd0);
    push_s       = 1'b0;
    pop_s        = valid_r && ready_i && !redirect_i;
    pc_next_s    = pc_r;
    count_next_s = count_r;
    drop_next_s  = drop_r;
    out_next_s   = out_r;

    if ((state_r == ST_RUN) && !rst && !redirect_i && (inflight_s < 3'd2)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end

    // A response is consumed either way; it only lands in the buffer when not stale.
    if (rsp_s && (drop_r == 2'd0) && !redirect_i) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    out_next_s = out_r + {1'b0, req_s} - {1'b0, rsp_s};

    if (redirect_i) begin
      pc_next_s    = redirect_target_s;
      count_next_s = 2'd0;
      drop_next_s  = out_next_s;
    end else begin
      if (req_s) begin
        pc_next_s = pc_r + AWIDTH'(3'd4);
      end else begin
        pc_next_s = pc_r;
      end
      count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
      if (rsp_s && (drop_r != 2'd0)) begin
        drop_next_s = drop_r - 2'd1;
      end else begin
        drop_next_s = drop_r;
      end
    end
  end

  // FSM next-state: a misaligned redirect parks fetch until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (misalign_hit_s) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_RUN;
    endcase
    valid_next_s = (count_next_s != 2'd0) && (state_next_s == ST_RUN);
  end

  // FSM state, PC, counters and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      pc_r     <= BASE_ADDR;
      count_r  <= 2'd0;
      out_r    <= 2'd0;
      drop_r   <= 2'd0;
      valid_r  <= 1'b0;
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      pcq_wr_r <= 1'b0;
      pcq_rd_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      count_r <= count_next_s;
      out_r   <= out_next_s;
      drop_r  <= drop_next_s;
      valid_r <= valid_next_s;
      // Flushing collapses the tail onto the head so pc_o does not move while empty.
      if (redirect_i) begin
        tail_r <= head_r;
      end else begin
        if (push_s) begin
          tail_r <= ~tail_r;
        end
        if (pop_s) begin
          head_r <= ~head_r;
        end
      end
      if (req_s) begin
        pcq_wr_r <= ~pcq_wr_r;
      end
      if (rsp_s) begin
        pcq_rd_r <= ~pcq_rd_r;
      end
    end
  end

  // Instruction buffer and in-flight PC queue storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_pc_r[i]   <= {AWIDTH{1'b0}};
        buf_insn_r[i] <= {DWIDTH{1'b0}};
        pcq_r[i]      <= {AWIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        buf_pc_r[tail_r]   <= pcq_r[pcq_rd_r];
        buf_insn_r[tail_r] <= imem_rdata_i;
      end
      if (req_s) begin
        pcq_r[pcq_wr_r] <= pc_r;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_r;

  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_r | misalign_hit_s;
    end
  end

  assign misalign_o = misalign_r;
`else
  assign misalign_o = 1'b0;
`endif

  assign imem_req_o  = req_s;
  assign imem_addr_o = pc_r;
  assign valid_o     = valid_r;
  assign pc_o        = buf_pc_r[head_r];
  assign insn_o      = buf_insn_r[head_r];

endmodule
